ptw_multilevel: RTL
===================

Name: ptw_multilevel

Overview:
- Parametrised hardware page-table walker; successor to the fixed two-level walker.
- Supports a configurable number of levels and configurable VPN/PTE/address widths.
- Takes a runtime root PPN instead of a fixed base.
- Detects leaf PTEs at any level (superpages), reports fault and leaf level, and supports flush.
- Sits between the TLB miss path and the memory port; one walk in flight.

Parameters:
LEVELS, 2, number of page-table levels (>=1); walk starts at level LEVELS-1
VPN_WIDTH, 10, VPN bits per level
PAGE_OFFSET, 12, page offset bits
VA_WIDTH, 32, virtual address width; must be >= LEVELS*VPN_WIDTH+PAGE_OFFSET
PTE_WIDTH, 32, PTE width; must be a power-of-two number of bytes
PPN_WIDTH, 22, PTE PPN field width; field occupies PTE[10+PPN_WIDTH-1:10]
ADDR_WIDTH, 32, memory address width; computed addresses are truncated to the low ADDR_WIDTH bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
satp_ppn_i  in  PPN_WIDTH  root table PPN; sampled at request accept
flush_i  in  1  abort current walk; no response is issued
ptw_req_valid_i  in  1  walk request valid
ptw_req_ready_o  out  1  walker idle and able to accept
ptw_vaddr_i  in  VA_WIDTH  virtual address
ptw_resp_valid_o  out  1  response valid
ptw_resp_ready_i  in  1  response accepted
ptw_pte_o  out  PTE_WIDTH  leaf PTE; 0 on fault
ptw_level_o  out  $clog2(LEVELS)+1  level at which the walk terminated
ptw_fault_o  out  1  page fault
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  ADDR_WIDTH  PTE address
mem_resp_valid_i  in  1  memory data valid
mem_resp_ready_o  out  1  walker accepts data
mem_data_i  in  PTE_WIDTH  PTE read data

Behaviour:
- Reset: state IDLE; ptw_req_ready_o=1; all other outputs 0; internal registers 0.
- All outputs are registered.
- States:
  - IDLE -> MEM_REQ on req_valid&&req_ready. Latch vaddr and satp_ppn; level=LEVELS-1; mem_addr={satp_ppn, vpn[level], log2(PTE_WIDTH/8) zeros}; mem_req_valid_o=1 next cycle; req_ready_o=0.
  - MEM_REQ: hold valid and addr stable until mem_req_ready_i. On handshake drop valid, set mem_resp_ready_o=1, go to MEM_WAIT.
  - MEM_WAIT: on mem_resp_valid_i, mem_resp_ready_o=0 and decode pte=mem_data_i:
    - V=0, or (R=0 and W=1) -> fault.
    - Leaf (R|X): superpage check: if level>0 and PPN bits [level*VPN_WIDTH-1:0] != 0 -> fault (misaligned); else success.
    - Non-leaf with level==0 -> fault.
    - Otherwise level-=1, mem_addr={pte.ppn, vpn[level], zeros}, go to MEM_REQ.
  - RESP: ptw_resp_valid_o=1; pte_o = leaf PTE from the current response data (not a stale register), or 0 on fault; level_o = terminating level; fault_o set accordingly. Hold until ptw_resp_ready_i. Then valid=0, req_ready=1, go to IDLE.
- Latency: accept at cycle T -> mem_req_valid at T+1. Each level costs 1 cycle after each memory handshake. Response valid the cycle after the last memory data handshake. Zero-wait memory, 2 levels: resp_valid at T+5.
- Flush:
  - In IDLE: no effect.
  - In MEM_REQ: request stays valid until accepted; after the handshake the data beat is still consumed, then go to IDLE with no response.
  - In MEM_WAIT: set an internal abort flag; consume the data, then go to IDLE.
  - In RESP: drop resp_valid next cycle, go to IDLE.
  - Flush coincident with request accept: the request is dropped; the walker stays in IDLE.
- mem_resp_valid_i outside MEM_WAIT: ignored (ready=0).
- ptw_req_valid_i outside IDLE: ignored.
- Reset mid-walk: immediate return to reset values; any in-flight memory beat is discarded by the memory side.
- No combinational paths from inputs to outputs.

Decomposition:
- Package ptw_pkg:
  - State enum: IDLE, MEM_REQ, MEM_WAIT, RESP.
  - PTE bit-position constants: V=0, R=1, W=2, X=3, PPN_LSB=10.
  - Function extracting vpn[level] from vaddr.
- Sub-module ptw_pte_check (combinational): inputs PTE and level; outputs is_leaf, fault, next_ppn.

Test Plan:
1. 2-level walk: satp_ppn=0x10, vaddr=0x0040_3123, zero-wait memory. Expect mem_addr 0x0001_0004; return L1 PTE 0x0000_8001. Expect mem_addr 0x0002_000C; return 0x0000_C00F. Expect resp pte=0x0000_C00F, level=0, fault=0, valid at T+5.
2. Superpage: same vaddr, L1 PTE 0x0010_0007 -> pte=0x0010_0007, level=1, fault=0, single memory read. L1 PTE 0x0004_0007 -> fault=1, pte=0, level=1.
3. Invalid and reserved PTEs: L1 0x0000_8000 (V=0) -> fault at level 1. L2 0x0000_C005 (W without R) -> fault at level 0. Non-leaf at level 0 (0x0000_C001) -> fault at level 0.
4. Backpressure: mem_req_ready low 3 cycles and ptw_resp_ready low 2 cycles -> addr and valid held stable; exactly one handshake each; req_ready returns 1 the cycle after the response handshake.
5. Flush: assert in MEM_WAIT with data delayed 4 cycles -> data consumed, no ptw_resp_valid, req_ready back to 1. Assert in RESP -> resp_valid drops the next cycle.
6. LEVELS=3, VPN_WIDTH=9, PTE_WIDTH=64, PPN_WIDTH=44, ADDR_WIDTH=56 (Sv39): 3-level walk with addresses using 3-bit zero offset; leaf at level 2 with a misaligned PPN -> fault.

Source files
------------

// File: rtl/ptw_multilevel_pkg.sv
// Shared types and PTE field positions for the multi-level page-table walker.
package ptw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } ptw_state_e;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;

  // VPN slice for a given level; caller narrows the result to its VPN width.
  function automatic logic [63:0] ptw_vpn(input logic [127:0] va, input int lvl,
                                          input int vpn_w, input int off);
    logic [63:0] mask;
    mask = (64'd1 << vpn_w) - 64'd1;
    return 64'(va >> (off + lvl * vpn_w)) & mask;
  endfunction

endpackage

// File: rtl/ptw_multilevel_if.sv
// Request/response and memory-port bundle of the walker; suffixes are walker-relative.
interface ptw_multilevel_if #(
  parameter int VA_WIDTH   = 32,
  parameter int PTE_WIDTH  = 32,
  parameter int PPN_WIDTH  = 22,
  parameter int ADDR_WIDTH = 32,
  parameter int LVL_W      = 2
) ();
  logic [PPN_WIDTH-1:0]  satp_ppn_i;
  logic                  flush_i;
  logic                  ptw_req_valid_i;
  logic                  ptw_req_ready_o;
  logic [VA_WIDTH-1:0]   ptw_vaddr_i;
  logic                  ptw_resp_valid_o;
  logic                  ptw_resp_ready_i;
  logic [PTE_WIDTH-1:0]  ptw_pte_o;
  logic [LVL_W-1:0]      ptw_level_o;
  logic                  ptw_fault_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_resp_valid_i;
  logic                  mem_resp_ready_o;
  logic [PTE_WIDTH-1:0]  mem_data_i;

  modport slave (
    input  satp_ppn_i, flush_i, ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_data_i,
    output ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o, ptw_level_o, ptw_fault_o,
           mem_req_valid_o, mem_addr_o, mem_resp_ready_o
  );

  modport master (
    output satp_ppn_i, flush_i, ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_data_i,
    input  ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o, ptw_level_o, ptw_fault_o,
           mem_req_valid_o, mem_addr_o, mem_resp_ready_o
  );
endinterface

// File: rtl/ptw_multilevel_pte_check.sv
// Combinational PTE decode: leaf detection, fault classification, next-level PPN.
module ptw_pte_check
  import ptw_pkg::*;
#(
  parameter int PTE_WIDTH = 32,
  parameter int PPN_WIDTH = 22,
  parameter int VPN_WIDTH = 10,
  parameter int LVL_W     = 2
) (
  input  logic [PTE_WIDTH-1:0] pte_i,
  input  logic [LVL_W-1:0]     level_i,
  output logic                 is_leaf_o,
  output logic                 fault_o,
  output logic [PPN_WIDTH-1:0] next_ppn_o
);
  logic misaligned;
  logic unused_pte;

  assign next_ppn_o = pte_i[PTE_PPN_LSB +: PPN_WIDTH];
  assign is_leaf_o  = pte_i[PTE_R] | pte_i[PTE_X];
  assign unused_pte = ^pte_i;

  // A superpage leaf must have its PPN bits below the covered VPN range clear.
  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < PPN_WIDTH; i++)
      if (next_ppn_o[i] && (i < int'(level_i) * VPN_WIDTH)) misaligned = 1'b1;
  end

  always_comb begin
    fault_o = 1'b0;
    if (!pte_i[PTE_V] || (!pte_i[PTE_R] && pte_i[PTE_W])) fault_o = 1'b1;
    else if (is_leaf_o)                                   fault_o = misaligned;
    else                                                  fault_o = (level_i == '0);
  end
endmodule

// File: rtl/ptw_multilevel.sv
// Parametrised page-table walker: one walk in flight, superpage leaves, flush abort.
module ptw_multilevel
  import ptw_pkg::*;
#(
  parameter int LEVELS      = 2,
  parameter int VPN_WIDTH   = 10,
  parameter int PAGE_OFFSET = 12,
  parameter int VA_WIDTH    = 32,
  parameter int PTE_WIDTH   = 32,
  parameter int PPN_WIDTH   = 22,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  ptw_multilevel_if.slave bus
);
  localparam int LVL_W = $clog2(LEVELS) + 1;
  localparam int ZB    = $clog2(PTE_WIDTH / 8);
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(LEVELS - 1);

  ptw_state_e            state_q, state_d;
  logic [VA_WIDTH-1:0]   vaddr_q, vaddr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mreq_q, mreq_d;
  logic                  mrdy_q, mrdy_d;
  logic                  rvld_q, rvld_d;
  logic [PTE_WIDTH-1:0]  rpte_q, rpte_d;
  logic [LVL_W-1:0]      rlvl_q, rlvl_d;
  logic                  rflt_q, rflt_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  abort_q, abort_d;

  logic                  chk_leaf, chk_fault;
  logic [PPN_WIDTH-1:0]  chk_ppn;

  function automatic logic [ADDR_WIDTH-1:0] pte_addr(input logic [PPN_WIDTH-1:0] ppn,
                                                     input logic [VA_WIDTH-1:0]  va,
                                                     input logic [LVL_W-1:0]     lvl);
    logic [VPN_WIDTH-1:0] idx;
    idx = VPN_WIDTH'(ptw_vpn(128'(va), int'(lvl), VPN_WIDTH, PAGE_OFFSET));
    return ADDR_WIDTH'({ppn, idx, {ZB{1'b0}}});
  endfunction

  ptw_pte_check #(
    .PTE_WIDTH(PTE_WIDTH), .PPN_WIDTH(PPN_WIDTH), .VPN_WIDTH(VPN_WIDTH), .LVL_W(LVL_W)
  ) u_chk (
    .pte_i     (bus.mem_data_i),
    .level_i   (level_q),
    .is_leaf_o (chk_leaf),
    .fault_o   (chk_fault),
    .next_ppn_o(chk_ppn)
  );

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    level_d   = level_q;
    addr_d    = addr_q;
    mreq_d    = mreq_q;
    mrdy_d    = mrdy_q;
    rvld_d    = rvld_q;
    rpte_d    = rpte_q;
    rlvl_d    = rlvl_q;
    rflt_d    = rflt_q;
    req_rdy_d = req_rdy_q;
    abort_d   = abort_q;
    unique case (state_q)
      IDLE: begin
        // A flush in the accept cycle swallows the request.
        if (bus.ptw_req_valid_i && req_rdy_q && !bus.flush_i) begin
          vaddr_d   = bus.ptw_vaddr_i;
          level_d   = TOP_LVL;
          addr_d    = pte_addr(bus.satp_ppn_i, bus.ptw_vaddr_i, TOP_LVL);
          mreq_d    = 1'b1;
          req_rdy_d = 1'b0;
          abort_d   = 1'b0;
          state_d   = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (bus.flush_i) abort_d = 1'b1;
        if (bus.mem_req_ready_i) begin
          mreq_d  = 1'b0;
          mrdy_d  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.flush_i) abort_d = 1'b1;
        if (bus.mem_resp_valid_i) begin
          mrdy_d = 1'b0;
          if (abort_q || bus.flush_i) begin
            abort_d   = 1'b0;
            req_rdy_d = 1'b1;
            state_d   = IDLE;
          end else if (chk_fault || chk_leaf) begin
            rvld_d  = 1'b1;
            rpte_d  = chk_fault ? '0 : bus.mem_data_i;
            rlvl_d  = level_q;
            rflt_d  = chk_fault;
            state_d = RESP;
          end else begin
            level_d = level_q - 1'b1;
            addr_d  = pte_addr(chk_ppn, vaddr_q, level_q - 1'b1);
            mreq_d  = 1'b1;
            state_d = MEM_REQ;
          end
        end
      end
      RESP: begin
        if (bus.flush_i || bus.ptw_resp_ready_i) begin
          rvld_d    = 1'b0;
          req_rdy_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vaddr_q   <= '0;
      level_q   <= '0;
      addr_q    <= '0;
      mreq_q    <= 1'b0;
      mrdy_q    <= 1'b0;
      rvld_q    <= 1'b0;
      rpte_q    <= '0;
      rlvl_q    <= '0;
      rflt_q    <= 1'b0;
      req_rdy_q <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vaddr_q   <= vaddr_d;
      level_q   <= level_d;
      addr_q    <= addr_d;
      mreq_q    <= mreq_d;
      mrdy_q    <= mrdy_d;
      rvld_q    <= rvld_d;
      rpte_q    <= rpte_d;
      rlvl_q    <= rlvl_d;
      rflt_q    <= rflt_d;
      req_rdy_q <= req_rdy_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.ptw_req_ready_o  = req_rdy_q;
  assign bus.ptw_resp_valid_o = rvld_q;
  assign bus.ptw_pte_o        = rpte_q;
  assign bus.ptw_level_o      = rlvl_q;
  assign bus.ptw_fault_o      = rflt_q;
  assign bus.mem_req_valid_o  = mreq_q;
  assign bus.mem_addr_o       = addr_q;
  assign bus.mem_resp_ready_o = mrdy_q;
endmodule
